// File: rtl/led_avalon_pkg.sv
// Shared register map, mode encoding and bit positions for the LED Avalon agent.
// Also provides the byte-lane merge used for byte-enabled writes.
package led_avalon_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_ROTATE = 2'd2,
    MODE_OFF    = 2'd3
  } led_mode_e;

  localparam int IRQ_EN_BIT   = 2;
  localparam int IRQ_PEND_BIT = 31;

  // Keep the old byte wherever its lane is disabled.
  function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] result;
    result = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) result[8*b +: 8] = new_val[8*b +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler: counts down from PERIOD and emits a one-cycle tick at zero.
// A PERIOD write reloads the counter one cycle later, suppressing the tick that cycle.
module led_tick_gen #(
  parameter logic [31:0] PERIOD_RST = 32'd50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] period,
  input  logic        reload,
  output logic        tick
);

  logic [31:0] count;
  logic        reload_q;

  assign tick = (count == '0) && !reload_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= PERIOD_RST;
      reload_q <= 1'b0;
    end else begin
      reload_q <= reload;
      if (reload_q || count == '0) begin
        count <= period;
      end else begin
        count <= count - 32'd1;
      end
    end
  end

endmodule

// File: rtl/led_avalon_agent.sv
// Avalon-MM responder driving the LED test bus: register file, tick-driven
// blink/rotate patterns and a tick interrupt. Fixed read latency of one cycle.
module led_avalon_agent
  import led_avalon_pkg::*;
#(
  parameter int          LED_W      = 4,
  parameter int unsigned PERIOD_RST = 50000000,
  parameter int          CNT_W      = 16
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  input  logic [3:0]       avs_byteenable,
  output logic [31:0]      avs_readdata,
  output logic             avs_readdatavalid,
  output logic             avs_waitrequest,
  output logic [LED_W-1:0] led_readdata,
  output logic             irq
);

  logic             wr_acc, rd_acc;
  logic             wr_data, wr_ctrl, wr_period, wr_status;
  logic             tick;
  logic [LED_W-1:0] data_q, data_nx, pattern_q, pattern_nx, rot, led_nx;
  led_mode_e        mode_q, mode_nx;
  logic             irq_en_q, irq_en_nx;
  logic [31:0]      period_q, period_nx;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_nx;
  logic             irq_pend_q, irq_pend_nx;
  logic             phase_q, phase_nx;
  logic [31:0]      rd_val;

  // A simultaneous read and write executes only the write.
  assign wr_acc    = avs_write && !avs_waitrequest;
  assign rd_acc    = avs_read && !avs_write && !avs_waitrequest;
  assign wr_data   = wr_acc && (avs_address == ADDR_DATA);
  assign wr_ctrl   = wr_acc && (avs_address == ADDR_CTRL);
  assign wr_period = wr_acc && (avs_address == ADDR_PERIOD);
  assign wr_status = wr_acc && (avs_address == ADDR_STATUS);

  led_tick_gen #(
    .PERIOD_RST(32'(PERIOD_RST))
  ) u_tick_gen (
    .clk   (clk_clk),
    .reset (reset_reset),
    .period(period_q),
    .reload(wr_period),
    .tick  (tick)
  );

  always_comb begin
    for (int i = 0; i < LED_W; i++) begin
      rot[i] = pattern_q[(i + LED_W - 1) % LED_W];
    end
  end

  always_comb begin
    data_nx = data_q;
    if (wr_data && avs_byteenable[0]) data_nx = avs_writedata[LED_W-1:0];

    mode_nx   = mode_q;
    irq_en_nx = irq_en_q;
    if (wr_ctrl && avs_byteenable[0]) begin
      mode_nx   = led_mode_e'(avs_writedata[1:0]);
      irq_en_nx = avs_writedata[IRQ_EN_BIT];
    end

    period_nx = wr_period ? apply_be(period_q, avs_writedata, avs_byteenable) : period_q;

    // Clear beats increment; set beats clear for the pending flag.
    tick_cnt_nx = tick_cnt_q;
    if (wr_status && avs_byteenable[0]) tick_cnt_nx = '0;
    else if (tick)                      tick_cnt_nx = tick_cnt_q + 1'b1;

    irq_pend_nx = irq_pend_q;
    if (tick && irq_en_q) irq_pend_nx = 1'b1;
    else if (wr_status && avs_byteenable[3] && avs_writedata[IRQ_PEND_BIT]) irq_pend_nx = 1'b0;

    phase_nx = phase_q ^ tick;

    pattern_nx = pattern_q;
    if (wr_data) pattern_nx = data_nx;
    else if (mode_nx == MODE_ROTATE && mode_q != MODE_ROTATE) pattern_nx = data_q;
    else if (tick && mode_q == MODE_ROTATE) pattern_nx = rot;

    // LEDs are computed from next state so they follow an event by one cycle.
    case (mode_nx)
      MODE_DIRECT: led_nx = data_nx;
      MODE_BLINK:  led_nx = phase_nx ? data_nx : '0;
      MODE_ROTATE: led_nx = pattern_nx;
      default:     led_nx = '0;
    endcase
  end

  always_comb begin
    rd_val = '0;
    case (avs_address)
      ADDR_DATA: rd_val[LED_W-1:0] = data_q;
      ADDR_CTRL: begin
        rd_val[1:0]       = mode_q;
        rd_val[IRQ_EN_BIT] = irq_en_q;
      end
      ADDR_PERIOD: rd_val = period_q;
      default: begin
        rd_val[CNT_W-1:0]    = tick_cnt_q;
        rd_val[IRQ_PEND_BIT] = irq_pend_q;
      end
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      data_q            <= '0;
      mode_q            <= MODE_DIRECT;
      irq_en_q          <= 1'b0;
      period_q          <= 32'(PERIOD_RST);
      tick_cnt_q        <= '0;
      irq_pend_q        <= 1'b0;
      phase_q           <= 1'b0;
      pattern_q         <= '0;
      led_readdata      <= '0;
      irq               <= 1'b0;
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
      avs_waitrequest   <= 1'b1;
    end else begin
      data_q            <= data_nx;
      mode_q            <= mode_nx;
      irq_en_q          <= irq_en_nx;
      period_q          <= period_nx;
      tick_cnt_q        <= tick_cnt_nx;
      irq_pend_q        <= irq_pend_nx;
      phase_q           <= phase_nx;
      pattern_q         <= pattern_nx;
      led_readdata      <= led_nx;
      irq               <= irq_pend_q & irq_en_q;
      avs_readdatavalid <= rd_acc;
      avs_waitrequest   <= 1'b0;
      if (rd_acc) avs_readdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_led_avalon_agent.sv
// Directed self-checking bench for led_avalon_agent: register access, rotate,
// blink, interrupt set/clear priority, read/write collision and mid-read reset.
module tb_led_avalon_agent;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic [1:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid, avs_waitrequest;
  logic [3:0]  led_readdata;
  logic        irq;

  int n_compared   = 0;
  int n_mismatched = 0;

  led_avalon_agent dut (
    .clk_clk          (clk_clk),
    .reset_reset      (reset_reset),
    .avs_address      (avs_address),
    .avs_read         (avs_read),
    .avs_write        (avs_write),
    .avs_writedata    (avs_writedata),
    .avs_byteenable   (avs_byteenable),
    .avs_readdata     (avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .avs_waitrequest  (avs_waitrequest),
    .led_readdata     (led_readdata),
    .irq              (irq)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic step();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [1:0] addr,
                               input logic [31:0] wd, input logic [3:0] be);
    avs_read       = rd;
    avs_write      = wr;
    avs_address    = addr;
    avs_writedata  = wd;
    avs_byteenable = be;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic doWrite(input logic [1:0] addr, input logic [31:0] wd, input logic [3:0] be);
    applyStimulus(1'b0, 1'b1, addr, wd, be);
    step();
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
  endtask

  task automatic doRead(input string tag, input logic [1:0] addr, output logic [31:0] data);
    applyStimulus(1'b1, 1'b0, addr, 32'h0, 4'h0);
    step();
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
    checkOutput({tag, "_valid"}, {31'b0, avs_readdatavalid}, 32'd1);
    data = avs_readdata;
  endtask

  initial begin
    logic [31:0] rdata;
    logic [3:0]  led_a, led_b, led_c;
    logic [31:0] boot_exp [4];
    logic [3:0]  rot_exp [4];
    boot_exp = '{32'd0, 32'd0, 32'd50000000, 32'd0};
    rot_exp  = '{4'h2, 4'h4, 4'h8, 4'h1};

    reset_reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
    repeat (3) step();
    checkOutput("rst_wait",  {31'b0, avs_waitrequest},   32'd1);
    checkOutput("rst_rdv",   {31'b0, avs_readdatavalid}, 32'd0);
    checkOutput("rst_rdata", avs_readdata,               32'd0);
    checkOutput("rst_led",   {28'b0, led_readdata},      32'd0);
    checkOutput("rst_irq",   {31'b0, irq},               32'd0);

    // First cycle after release still stalls; the held read goes in a cycle later.
    reset_reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 4'h0);
    checkOutput("wait_first", {31'b0, avs_waitrequest}, 32'd1);
    step();
    checkOutput("wait_second", {31'b0, avs_waitrequest},   32'd0);
    checkOutput("rdv_stalled", {31'b0, avs_readdatavalid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("boot_rdv",   {31'b0, avs_readdatavalid}, 32'd1);
      checkOutput("boot_rdata", avs_readdata,               boot_exp[i]);
      if (i < 3) applyStimulus(1'b1, 1'b0, 2'(i + 1), 32'h0, 4'h0);
      else       applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
    end
    step();
    checkOutput("boot_rdv_end", {31'b0, avs_readdatavalid}, 32'd0);

    // Direct mode and byte enables.
    doWrite(2'd0, 32'h0000000A, 4'h1);
    doWrite(2'd1, 32'h00000000, 4'h1);
    checkOutput("direct_led", {28'b0, led_readdata}, 32'h0000000A);
    doWrite(2'd0, 32'h00000005, 4'h0);
    doRead("data_be0", 2'd0, rdata);
    checkOutput("data_be0", rdata, 32'h0000000A);

    // Rotate with PERIOD=2: ticks land every third cycle.
    doWrite(2'd2, 32'd2, 4'hF);
    doWrite(2'd1, 32'd2, 4'h1);
    doWrite(2'd0, 32'd1, 4'h1);
    checkOutput("rot_load", {28'b0, led_readdata}, 32'd1);
    step();
    checkOutput("rot_hold", {28'b0, led_readdata}, 32'd1);
    step();
    for (int k = 0; k < 4; k++) begin
      checkOutput("rot_step", {28'b0, led_readdata}, {28'b0, rot_exp[k]});
      step();
      step();
      checkOutput("rot_step_hold", {28'b0, led_readdata}, {28'b0, rot_exp[k]});
      step();
    end
    doRead("status_rot", 2'd3, rdata);
    checkOutput("status_rot", rdata, 32'd5);
    checkOutput("irq_off", {31'b0, irq}, 32'd0);

    // Blink with PERIOD=0 and interrupt enabled.
    doWrite(2'd2, 32'd0, 4'hF);
    doWrite(2'd1, 32'd5, 4'h1);
    step();
    step();
    checkOutput("blink_irq", {31'b0, irq}, 32'd1);
    led_a = led_readdata;
    step();
    led_b = led_readdata;
    step();
    led_c = led_readdata;
    checkOutput("blink_toggle_ab", {28'b0, led_a ^ led_b}, 32'd1);
    checkOutput("blink_or_ab",     {28'b0, led_a | led_b}, 32'd1);
    checkOutput("blink_toggle_bc", {28'b0, led_b ^ led_c}, 32'd1);

    doWrite(2'd3, 32'h80000000, 4'h8);
    doRead("pend_set_wins", 2'd3, rdata);
    checkOutput("pend_set_wins", {31'b0, rdata[31]}, 32'd1);
    checkOutput("irq_held", {31'b0, irq}, 32'd1);
    doWrite(2'd3, 32'h00000000, 4'h1);
    doRead("cnt_clear_wins", 2'd3, rdata);
    checkOutput("cnt_clear_wins", rdata, 32'h80000000);

    doWrite(2'd1, 32'd0, 4'h1);
    doWrite(2'd3, 32'h80000000, 4'h8);
    doRead("pend_cleared", 2'd3, rdata);
    checkOutput("pend_cleared", {31'b0, rdata[31]}, 32'd0);
    checkOutput("irq_cleared", {31'b0, irq}, 32'd0);

    // Read and write together: only the write happens.
    applyStimulus(1'b1, 1'b1, 2'd0, 32'h00000003, 4'h1);
    step();
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
    checkOutput("rw_no_rdv", {31'b0, avs_readdatavalid}, 32'd0);
    checkOutput("rw_led",    {28'b0, led_readdata},      32'd3);
    doRead("rw_data", 2'd0, rdata);
    checkOutput("rw_data", rdata, 32'd3);

    // Reset lands on the edge that would have returned this read.
    applyStimulus(1'b1, 1'b0, 2'd1, 32'h0, 4'h0);
    reset_reset = 1'b1;
    step();
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
    checkOutput("mid_rst_rdv",   {31'b0, avs_readdatavalid}, 32'd0);
    checkOutput("mid_rst_rdata", avs_readdata,               32'd0);
    checkOutput("mid_rst_wait",  {31'b0, avs_waitrequest},   32'd1);
    checkOutput("mid_rst_led",   {28'b0, led_readdata},      32'd0);
    checkOutput("mid_rst_irq",   {31'b0, irq},               32'd0);
    step();
    reset_reset = 1'b0;
    step();
    doRead("post_rst_period", 2'd2, rdata);
    checkOutput("post_rst_period", rdata, 32'd50000000);
    doRead("post_rst_data", 2'd0, rdata);
    checkOutput("post_rst_data", rdata, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
